pendigits_stream_frontend: RTL and testbench

PENDIGITS_STREAM_FRONTEND -- requirements
Module: pendigits_stream_frontend

---
 rtl/pendigits_stream_frontend.sv | 140 ++++++++++++++
 tb/tb_pendigits_stream_frontend.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pendigits_stream_frontend.sv
// rtl/pendigits_stream_frontend.sv - feature frame loader and result holder around a pen-digits classifier core
module pendigits_stream_frontend #(
  parameter int FEAT_CNT     = 16,
  parameter int FEAT_BITS    = 4,
  parameter int CLASS_CNT    = 10,
  parameter int INFER_CYCLES = 52
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEAT_BITS-1:0]           in_data,
  input  logic                           in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0]  features,
  input  logic [$clog2(CLASS_CNT)-1:0]   core_prediction,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]   out_class,
  output logic                           out_err
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CNT_W = (INFER_CYCLES > 1) ? $clog2(INFER_CYCLES) : 1;
  localparam int CLS_W = $clog2(CLASS_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INFER_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0]               run_cnt_q, run_cnt_d;
  logic [FEAT_CNT*FEAT_BITS-1:0]  features_q, features_d;
  logic [CLS_W-1:0]               out_class_q, out_class_d;
  logic                           err_q, err_d;
  logic                           in_hs;

  assign in_hs = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      beat_idx_q  <= '0;
      run_cnt_q   <= '0;
      features_q  <= '0;
      out_class_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      run_cnt_q   <= run_cnt_d;
      features_q  <= features_d;
      out_class_q <= out_class_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (in_last) begin
            state_d = RUN;
          end else if (beat_idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (in_hs && in_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (run_cnt_q == LAST_CNT) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Beat index stops at the last slot; overlong frames fall through to DRAIN instead of wrapping.
  always_comb begin
    beat_idx_d  = beat_idx_q;
    run_cnt_d   = run_cnt_q;
    features_d  = features_q;
    out_class_d = out_class_q;
    err_d       = err_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          features_d[int'(beat_idx_q)*FEAT_BITS +: FEAT_BITS] = in_data;
          if (in_last) begin
            err_d = (beat_idx_q != LAST_IDX);
          end else if (beat_idx_q == LAST_IDX) begin
            err_d = 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
          end
        end
      end
      RUN: begin
        if (run_cnt_q == LAST_CNT) begin
          run_cnt_d   = '0;
          out_class_d = core_prediction;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          beat_idx_d = '0;
          err_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD) || (state_q == DRAIN);
    out_valid = (state_q == HOLD);
    features  = features_q;
    out_class = out_class_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_pendigits_stream_frontend.sv
// tb/tb_pendigits_stream_frontend.sv - scoreboard bench for pendigits_stream_frontend
module tb_pendigits_stream_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic [63:0] features;
  logic [3:0]  core_prediction;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic        out_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  cls;
    logic        err;
    logic [63:0] feat;
    int          rise;
    int          stall;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   in_hold  = 1'b0;
  bit   released = 1'b0;
  int   stall_left = 0;

  pendigits_stream_frontend dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .features        (features),
    .core_prediction (core_prediction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_class       (out_class),
    .out_err         (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign core_prediction = 4'(cyc % 10);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input logic last, input int gap, output int c0);
    int w;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("beat_accept_timeout", 64'(in_ready), 64'd1);
    c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [3:0] beat_val(input int mode, input int k);
    case (mode)
      0:       return 4'(k);
      1:       return 4'(5 - k);
      2:       return (k < 16) ? 4'(15 - k) : 4'hA;
      3:       return 4'h7;
      default: return 4'h3;
    endcase
  endfunction

  task automatic send_frame(input int n, input int mode, input bit gaps, input logic [63:0] exp_feat,
                            input logic exp_err, input int stall, input bit push);
    int   c0;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      send_beat(beat_val(mode, k), (k == n - 1), gaps ? int'($urandom_range(0, 3)) : 0, c0);
    end
    if (push) begin
      e.cls   = 4'((c0 + 52) % 10);
      e.err   = exp_err;
      e.feat  = exp_feat;
      e.rise  = c0 + 53;
      e.stall = stall;
      sb.push_back(e);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (released) begin
        chk("in_ready_after_release", 64'(in_ready), 64'd1);
        chk("out_valid_after_release", 64'(out_valid), 64'd0);
        released = 1'b0;
        in_hold  = 1'b0;
      end
      if (out_valid) begin
        if (!in_hold) begin
          in_hold = 1'b1;
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            stall_left = 0;
          end else begin
            cur = sb.pop_front();
            chk("out_class", 64'(out_class), 64'(cur.cls));
            chk("out_err", 64'(out_err), 64'(cur.err));
            chk("features", features, cur.feat);
            chk("rise_cycle", 64'(cyc), 64'(cur.rise));
            stall_left = cur.stall;
          end
        end else begin
          chk("hold_class_stable", 64'(out_class), 64'(cur.cls));
          chk("hold_err_stable", 64'(out_err), 64'(cur.err));
          chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        if (stall_left > 0) begin
          stall_left--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          released  = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_features", features, 64'd0);
    chk("reset_out_class", 64'(out_class), 64'd0);
    chk("reset_out_err", 64'(out_err), 64'd0);

    send_frame(16, 0, 1'b0, 64'hFEDCBA9876543210, 1'b0, 0, 1'b1);
    send_frame(5,  1, 1'b0, 64'hFEDCBA9876512345, 1'b1, 0, 1'b1);
    send_frame(20, 2, 1'b0, 64'h0123456789ABCDEF, 1'b1, 0, 1'b1);
    send_frame(16, 3, 1'b0, 64'h7777777777777777, 1'b0, 10, 1'b1);
    send_frame(16, 0, 1'b1, 64'hFEDCBA9876543210, 1'b0, 0, 1'b1);

    // Abort a frame in RUN cycle 20; its result must never appear.
    send_frame(16, 4, 1'b0, 64'h0, 1'b0, 0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_reset_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_reset_in_ready", 64'(in_ready), 64'd1);
    chk("midrun_reset_features", features, 64'd0);
    chk("midrun_reset_out_class", 64'(out_class), 64'd0);
    chk("midrun_reset_out_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_result_after_abort", 64'(out_valid), 64'd0);

    send_frame(16, 0, 1'b1, 64'hFEDCBA9876543210, 1'b0, 0, 1'b1);

    w = 0;
    while ((sb.size() != 0 || in_hold) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
